uart_tx_arb: RTL and testbench

Round-robin arbiter that shares the single UART transmitter (`tx`: `send`/`in`/`busy`) among `N_REQ` requesters. Each requester streams bytes with a last-byte flag; the arbiter locks the grant to one requester for a whole packet, so multi-byte messages are never interleaved. It sits between the message sources (debounced keys, rx echo, status reporters) and `tx`. It owns the `send` level-hold handshake, so a slow baud-domain `tx` sees a stable request.

---
 rtl/uart_tx_arb_if.sv | 32 +++
 rtl/uart_tx_arb.sv | 172 +++++++++++++++++
 tb/tb_uart_tx_arb.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_arb_if.sv
// ============================================================================
// Module  : uart_tx_arb_if
// Brief   : Requester-side and tx-side bundle of the UART transmit arbiter.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

interface uart_tx_arb_if #(
  parameter int N_REQ = 4
) ();
  logic [N_REQ-1:0]   req_valid;
  logic [8*N_REQ-1:0] req_data;
  logic [N_REQ-1:0]   req_last;
  logic [N_REQ-1:0]   req_ready;
  logic [N_REQ-1:0]   grant;
  logic               tx_send;
  logic [7:0]         tx_data;
  logic               tx_busy;
  logic               err;

  modport master (
    input  req_valid, req_data, req_last, tx_busy,
    output req_ready, grant, tx_send, tx_data, err
  );

  modport slave (
    output req_valid, req_data, req_last, tx_busy,
    input  req_ready, grant, tx_send, tx_data, err
  );
endinterface

`default_nettype wire

// File: rtl/uart_tx_arb.sv
// ============================================================================
// Module  : uart_tx_arb
// Brief   : Packet-locked round-robin arbiter in front of a single UART tx.
//           Optional send watchdog enabled by defining UART_TX_ARB_WDOG_EN.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module uart_tx_arb #(
  parameter int N_REQ   = 4,
  parameter int TIMEOUT = 1023
) (
  input  logic           clk,
  input  logic           rst,
  uart_tx_arb_if.master  bus
);

  localparam int PW = $clog2(N_REQ);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_SEND = 2'd2,
    S_WAIT = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic [PW-1:0]    owner_q, owner_d;
  logic [PW-1:0]    ptr_q, ptr_d;
  logic             last_q, last_d;
  logic [7:0]       tx_data_q, tx_data_d;

  logic             win_found;
  logic [PW-1:0]    win_idx;
  logic [PW-1:0]    cand;
  int               idx;
  logic [PW-1:0]    ptr_after;
  logic [7:0]       owner_byte;
  logic             wd_expire;

`ifdef UART_TX_ARB_WDOG_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] wd_cnt_q, wd_cnt_d;
  logic          err_q, err_d;

  assign wd_expire = (wd_cnt_q == CW'(TIMEOUT - 1));

  always_comb begin
    wd_cnt_d = '0;
    err_d    = err_q;
    if (state_q == S_SEND) begin
      wd_cnt_d = wd_cnt_q + 1'b1;
      if (!bus.tx_busy && wd_expire) begin
        err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wd_cnt_q <= '0;
      err_q    <= 1'b0;
    end else begin
      wd_cnt_q <= wd_cnt_d;
      err_q    <= err_d;
    end
  end

  assign bus.err = err_q;
`else
  localparam int unused_timeout = TIMEOUT;
  assign wd_expire = 1'b0;
  assign bus.err   = 1'b0;
`endif

  // First requesting index at or above ptr, wrapping modulo N_REQ.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    idx       = 0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = int'(ptr_q) + k;
      if (idx >= N_REQ) begin
        idx = idx - N_REQ;
      end
      cand = PW'(idx);
      if (!win_found && bus.req_valid[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  assign ptr_after  = (owner_q == PW'(N_REQ - 1)) ? '0 : owner_q + 1'b1;
  assign owner_byte = bus.req_data[{owner_q, 3'b000} +: 8];

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    owner_d   = owner_q;
    ptr_d     = ptr_q;
    last_d    = last_q;
    tx_data_d = tx_data_q;
    case (state_q)
      S_IDLE: begin
        if (win_found) begin
          grant_d = N_REQ'(1) << win_idx;
          owner_d = win_idx;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        // Busy still high from the previous byte must not count as a handshake.
        if (!bus.tx_busy && bus.req_valid[owner_q]) begin
          tx_data_d = owner_byte;
          last_d    = bus.req_last[owner_q];
          state_d   = S_SEND;
        end
      end
      S_SEND: begin
        if (bus.tx_busy) begin
          state_d = S_WAIT;
        end else if (wd_expire) begin
          state_d = S_IDLE;
          grant_d = '0;
          ptr_d   = ptr_after;
        end
      end
      S_WAIT: begin
        if (!bus.tx_busy) begin
          if (last_q) begin
            state_d = S_IDLE;
            grant_d = '0;
            ptr_d   = ptr_after;
          end else begin
            state_d = S_LOAD;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      grant_q   <= '0;
      owner_q   <= '0;
      ptr_q     <= '0;
      last_q    <= 1'b0;
      tx_data_q <= 8'h00;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      owner_q   <= owner_d;
      ptr_q     <= ptr_d;
      last_q    <= last_d;
      tx_data_q <= tx_data_d;
    end
  end

  // tx_send decodes the state register so reset removes it without a clock.
  assign bus.req_ready = (state_q == S_LOAD && !bus.tx_busy) ? grant_q : '0;
  assign bus.grant     = grant_q;
  assign bus.tx_send   = (state_q == S_SEND);
  assign bus.tx_data   = tx_data_q;

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_arb.sv
// ============================================================================
// Module  : tb_uart_tx_arb
// Brief   : Scoreboard bench for uart_tx_arb with a 20-cycle-busy tx model.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_uart_tx_arb;
  localparam int N = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;

  initial forever #5 clk = ~clk;

  uart_tx_arb_if #(.N_REQ(N)) bus ();

  uart_tx_arb #(.N_REQ(N), .TIMEOUT(15)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [8:0]  src_q [N][$];
  logic [11:0] exp_q [$];
  logic [N-1:0] en = '1;
  logic        tx_dead = 1'b0;
  int          busy_cnt = 0;
  int          ready_cnt [N];
  int          bad_ready = 0;
  int          bad_grant = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] enc(input logic [N-1:0] g);
    enc = 4'hF;
    for (int i = 0; i < N; i++) if (g[i]) enc = 4'(i);
  endfunction

  function automatic bit srcs_empty();
    srcs_empty = 1'b1;
    for (int i = 0; i < N; i++) if (src_q[i].size() != 0) srcs_empty = 1'b0;
  endfunction

  // tx model and requester drivers, all updated on the falling edge
  initial begin
    logic [N-1:0]   v, l, acc;
    logic [8*N-1:0] d;
    logic [8:0]     h;
    logic [11:0]    obs;
    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.req_last  = '0;
    bus.tx_busy   = 1'b0;
    for (int i = 0; i < N; i++) ready_cnt[i] = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        busy_cnt    = 0;
        bus.tx_busy = 1'b0;
      end else if (busy_cnt > 0) begin
        busy_cnt--;
        if (busy_cnt == 0) bus.tx_busy = 1'b0;
      end else if (bus.tx_send && !tx_dead) begin
        obs = {enc(bus.grant), bus.tx_data};
        if (exp_q.size() == 0) check_eq("sb_unexpected", 32'(obs), 32'hFFFF_FFFF);
        else check_eq("sb_byte", 32'(obs), 32'(exp_q.pop_front()));
        bus.tx_busy = 1'b1;
        busy_cnt    = 20;
      end
      v = '0; d = '0; l = '0;
      for (int i = 0; i < N; i++) begin
        if (en[i] && src_q[i].size() > 0) begin
          h          = src_q[i][0];
          v[i]       = 1'b1;
          d[8*i +: 8] = h[7:0];
          l[i]       = h[8];
        end
      end
      bus.req_valid = v;
      bus.req_data  = d;
      bus.req_last  = l;
      #1;
      acc = bus.req_ready & bus.req_valid;
      for (int i = 0; i < N; i++) begin
        if (acc[i]) begin
          h = src_q[i].pop_front();
          ready_cnt[i]++;
        end
      end
      if ((bus.req_ready & ~bus.grant) != '0) bad_ready++;
      if ((bus.grant & (bus.grant - 1'b1)) != '0) bad_grant++;
    end
  end

  task automatic step();
    @(negedge clk);
    #2;
  endtask

  task automatic clear_counts();
    for (int i = 0; i < N; i++) ready_cnt[i] = 0;
    bad_ready = 0;
    bad_grant = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    for (int i = 0; i < N; i++) src_q[i].delete();
    exp_q.delete();
    repeat (2) step();
    rst = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (n < 2000 && !(exp_q.size() == 0 && bus.grant == '0 && !bus.tx_busy && srcs_empty())) begin
      step();
      n++;
    end
    check_eq(tag, 32'(n < 2000), 32'd1);
  endtask

  initial begin
    int n;
    // reset state
    step();
    check_eq("rst_grant", 32'(bus.grant), 0);
    check_eq("rst_ready", 32'(bus.req_ready), 0);
    check_eq("rst_send", 32'(bus.tx_send), 0);
    check_eq("rst_data", 32'(bus.tx_data), 0);
    check_eq("rst_err", 32'(bus.err), 0);
    do_reset();

    // single requester, two-byte packet, with first-byte latency
    clear_counts();
    src_q[0].push_back({1'b0, 8'h41});
    src_q[0].push_back({1'b1, 8'h42});
    exp_q.push_back({4'd0, 8'h41});
    exp_q.push_back({4'd0, 8'h42});
    step();
    check_eq("lat_grant0", 32'(bus.grant), 0);
    step();
    check_eq("lat_grant1", 32'(bus.grant), 32'b0001);
    check_eq("lat_send1", 32'(bus.tx_send), 0);
    check_eq("lat_ready1", 32'(bus.req_ready), 32'b0001);
    step();
    check_eq("lat_send2", 32'(bus.tx_send), 1);
    check_eq("lat_data2", 32'(bus.tx_data), 32'h41);
    wait_idle("single_done");
    check_eq("single_ready_cnt", 32'(ready_cnt[0]), 2);
    check_eq("single_grant_end", 32'(bus.grant), 0);
    check_eq("single_bad_ready", 32'(bad_ready), 0);

    // contention from reset: order 0,1,2,3 then ptr wraps to 0
    do_reset();
    clear_counts();
    for (int i = 0; i < N; i++) begin
      src_q[i].push_back({1'b1, 8'hA0 + 8'(i)});
      exp_q.push_back({4'(i), 8'hA0 + 8'(i)});
    end
    wait_idle("contend_done");
    src_q[0].push_back({1'b1, 8'hB0});
    src_q[1].push_back({1'b1, 8'hB1});
    exp_q.push_back({4'd0, 8'hB0});
    exp_q.push_back({4'd1, 8'hB1});
    wait_idle("wrap_done");
    check_eq("contend_bad_grant", 32'(bad_grant), 0);

    // packet lock: req 2 arrives during req 1's 3-byte packet
    clear_counts();
    en = 4'b1011;
    src_q[1].push_back({1'b0, 8'hC0});
    src_q[1].push_back({1'b0, 8'hC1});
    src_q[1].push_back({1'b1, 8'hC2});
    src_q[2].push_back({1'b1, 8'hD0});
    exp_q.push_back({4'd1, 8'hC0});
    exp_q.push_back({4'd1, 8'hC1});
    exp_q.push_back({4'd1, 8'hC2});
    exp_q.push_back({4'd2, 8'hD0});
    n = 0;
    while (ready_cnt[1] < 1 && n < 200) begin step(); n++; end
    check_eq("lock_first_byte", 32'(n < 200), 1);
    en = '1;
    wait_idle("lock_done");
    check_eq("lock_bad_ready", 32'(bad_ready), 0);

    // owner stall: req 0 drops valid mid-packet, req 1 waits
    clear_counts();
    en = 4'b1101;
    src_q[0].push_back({1'b0, 8'hE0});
    src_q[0].push_back({1'b1, 8'hE1});
    src_q[1].push_back({1'b1, 8'hF1});
    exp_q.push_back({4'd0, 8'hE0});
    exp_q.push_back({4'd0, 8'hE1});
    exp_q.push_back({4'd1, 8'hF1});
    n = 0;
    while (ready_cnt[0] < 1 && n < 200) begin step(); n++; end
    en = 4'b1110;
    while (!bus.tx_busy && n < 400) begin step(); n++; end
    while (bus.tx_busy && n < 400) begin step(); n++; end
    check_eq("stall_setup", 32'(n < 400), 1);
    begin
      int g_bad, s_bad;
      g_bad = 0;
      s_bad = 0;
      for (int c = 0; c < 50; c++) begin
        if (bus.grant !== 4'b0001) g_bad++;
        if (bus.tx_send !== 1'b0) s_bad++;
        step();
      end
      check_eq("stall_grant", 32'(g_bad), 0);
      check_eq("stall_send", 32'(s_bad), 0);
    end
    check_eq("stall_other_ready", 32'(ready_cnt[1]), 0);
    check_eq("stall_bad_ready", 32'(bad_ready), 0);
    en = '1;
    wait_idle("stall_done");
    check_eq("stall_ready0", 32'(ready_cnt[0]), 2);
    check_eq("stall_ready1", 32'(ready_cnt[1]), 1);

    // watchdog: tx never answers
    tx_dead = 1'b1;
    src_q[2].push_back({1'b1, 8'h77});
    n = 0;
    while (!bus.tx_send && n < 100) begin step(); n++; end
    check_eq("wd_send_seen", 32'(bus.tx_send), 1);
    check_eq("wd_data", 32'(bus.tx_data), 32'h77);
    n = 0;
`ifdef UART_TX_ARB_WDOG_EN
    while (bus.tx_send && n < 1100) begin n++; step(); end
    check_eq("wd_send_cycles", 32'(n), 15);
    check_eq("wd_err", 32'(bus.err), 1);
    check_eq("wd_grant", 32'(bus.grant), 0);
    repeat (20) step();
    check_eq("wd_err_sticky", 32'(bus.err), 1);
    src_q[3].push_back({1'b1, 8'h78});
    n = 0;
    while (!bus.tx_send && n < 100) begin step(); n++; end
    step();
`else
    while (bus.tx_send && n < 1000) begin n++; step(); end
    check_eq("nowd_send_cycles", 32'(n), 1000);
    check_eq("nowd_err", 32'(bus.err), 0);
`endif

    // asynchronous reset while tx_send is high
    check_eq("rstmid_pre_send", 32'(bus.tx_send), 1);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check_eq("rstmid_send", 32'(bus.tx_send), 0);
    check_eq("rstmid_grant", 32'(bus.grant), 0);
    check_eq("rstmid_ready", 32'(bus.req_ready), 0);
    check_eq("rstmid_data", 32'(bus.tx_data), 0);
    check_eq("rstmid_err", 32'(bus.err), 0);
    for (int i = 0; i < N; i++) src_q[i].delete();
    exp_q.delete();
    tx_dead = 1'b0;
    repeat (2) step();
    rst = 1'b0;

    // ptr restarts at 0 after reset
    src_q[0].push_back({1'b1, 8'h5A});
    src_q[2].push_back({1'b1, 8'h5C});
    exp_q.push_back({4'd0, 8'h5A});
    exp_q.push_back({4'd2, 8'h5C});
    wait_idle("post_rst_done");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
